// File: rtl/agc_rupt_pkg.sv
// ---------------------------------------------------------------------------
// agc_rupt_pkg
// Shared definitions for the interrupt priority block and its helpers.
//   rupt_state_t : controller state (IDLE, OFFER, SERVICE)
//   NRUPT_DEF    : default number of interrupt sources
//   RUPT_BASE    : base of the interrupt vector table (octal 04000)
//   RUPT_STRIDE  : words between consecutive interrupt vectors
// ---------------------------------------------------------------------------
package agc_rupt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OFFER   = 2'd1,
      SERVICE = 2'd2
   } rupt_state_t;

   localparam int          NRUPT_DEF   = 10;
   localparam logic [11:0] RUPT_BASE   = 12'o4000;
   localparam int          RUPT_STRIDE = 4;

endpackage

// File: rtl/rupt_lock_timer.sv
// ---------------------------------------------------------------------------
// rupt_lock_timer
// Counts T12 strobes spent inside an interrupt service routine and flags
// when the service has run for LOCK_LIM strobes. The count saturates at
// the limit so the alarm cannot wrap back off.
//   clock   : system clock
//   reset   : asynchronous, active-high
//   clear   : restart the count (service entry / exit)
//   tick    : one T12 strobe while in service
//   expired : registered, high once LOCK_LIM ticks have been counted
// ---------------------------------------------------------------------------
module rupt_lock_timer #(
   parameter int LOCK_LIM = 1400
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int               CNT_W = $clog2(LOCK_LIM + 1);
   localparam logic [CNT_W-1:0] LIM_V = CNT_W'(LOCK_LIM);
   localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

   logic [CNT_W-1:0] lock_count;

   // The alarm flag is computed from the incremented value so that it rises
   // on the very edge at which the count reaches the limit, not one later.
   // Clear has priority over a coincident tick.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_count <= '0;
         expired    <= 1'b0;
      end else if (clear) begin
         lock_count <= '0;
         expired    <= 1'b0;
      end else if (tick && (lock_count != LIM_V)) begin
         lock_count <= lock_count + ONE_V;
         expired    <= ((lock_count + ONE_V) == LIM_V);
      end
   end

endmodule

// File: rtl/rupt_priority.sv
// ---------------------------------------------------------------------------
// rupt_priority
// Interrupt priority controller. Latches request pulses, and at each T12
// strobe (when not inhibited) offers the highest-priority pending source
// to the sequencer. The sequencer takes the interrupt with KRPT and ends
// it with RESUME. A lock timer raises RLOCK if a service runs too long.
//   SIM_CLK  : system clock, rising edge
//   SIM_RST  : asynchronous, active-high reset
//   RQ_PLS   : one-cycle request pulses, bit 0 is highest priority
//   T12      : end-of-memory-cycle strobe, the only evaluation point
//   INHINT   : program interrupt inhibit (level)
//   OVINH    : overflow inhibit (level)
//   EXTP     : extend pending, bars interrupts (level)
//   KRPT     : sequencer takes the offered interrupt
//   RESUME   : service routine complete
//   RUPTOR   : interrupt offered (registered)
//   IIP      : interrupt in progress (registered)
//   RADDR    : vector address of the latched source
//   PEND     : latched pending requests
//   RLOCK    : rupt-lock alarm (registered)
// ---------------------------------------------------------------------------
module rupt_priority
   import agc_rupt_pkg::*;
#(
   parameter int NRUPT    = NRUPT_DEF,
   parameter int LOCK_LIM = 1400
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic [NRUPT-1:0] RQ_PLS,
   input  logic             T12,
   input  logic             INHINT,
   input  logic             OVINH,
   input  logic             EXTP,
   input  logic             KRPT,
   input  logic             RESUME,
   output logic             RUPTOR,
   output logic             IIP,
   output logic [11:0]      RADDR,
   output logic [NRUPT-1:0] PEND,
   output logic             RLOCK
);

   localparam int IDX_W = $clog2((NRUPT > 1) ? NRUPT : 2);

   rupt_state_t      state;
   rupt_state_t      next_state;
   logic [NRUPT-1:0] pend_q;
   logic [NRUPT-1:0] clear_mask;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] low_idx;
   logic             inhibit;
   logic             do_offer;
   logic             do_take;
   logic             do_resume;
   logic             lock_expired;

   assign inhibit   = INHINT | OVINH | EXTP;
   assign do_offer  = (state == IDLE) && T12 && (|pend_q) && !inhibit;
   assign do_take   = (state == OFFER) && KRPT;
   assign do_resume = (state == SERVICE) && RESUME;

   // Priority encoder: scanning from the top down lets the lowest set bit,
   // i.e. the highest-priority source, overwrite any earlier hit.
   always_comb begin
      low_idx = '0;
      for (int i = NRUPT - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            low_idx = IDX_W'(i);
         end
      end
   end

   // Only the taken source is cleared from the pending set; a request pulse
   // arriving on the same edge is ORed back in afterwards so it is not lost.
   always_comb begin
      clear_mask = '0;
      if (do_take) begin
         clear_mask[idx_q] = 1'b1;
      end
   end

   // Next-state logic. KRPT is checked before the T12 inhibit test so that a
   // take coincident with an inhibited strobe still enters service.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (do_offer) begin
               next_state = OFFER;
            end
         end
         OFFER: begin
            if (KRPT) begin
               next_state = SERVICE;
            end else if (T12 && inhibit) begin
               next_state = IDLE;
            end
         end
         SERVICE: begin
            if (RESUME) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Pending set and latched source index. The index is captured only when
   // an offer is made, so later arrivals cannot redirect an offer in flight.
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         pend_q <= '0;
         idx_q  <= '0;
      end else begin
         pend_q <= (pend_q & ~clear_mask) | RQ_PLS;
         if (do_offer) begin
            idx_q <= low_idx;
         end
      end
   end

   // RUPTOR and IIP are flops loaded from the next state, keeping them free
   // of any combinational path from the inputs.
   always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
      if (SIM_RST) begin
         RUPTOR <= 1'b0;
         IIP    <= 1'b0;
      end else begin
         RUPTOR <= (next_state == OFFER);
         IIP    <= (next_state == SERVICE);
      end
   end

   // The lock timer is restarted both on entry and on exit of service, so
   // its alarm drops on the RESUME edge and is never seen outside service.
   rupt_lock_timer #(
      .LOCK_LIM (LOCK_LIM)
   ) u_lock_timer (
      .clock   (SIM_CLK),
      .reset   (SIM_RST),
      .clear   (do_take | do_resume),
      .tick    (T12 && (state == SERVICE)),
      .expired (lock_expired)
   );

   assign RLOCK = lock_expired;
   assign PEND  = pend_q;
   assign RADDR = RUPT_BASE + 12'((int'(idx_q) + 1) * RUPT_STRIDE);

endmodule

// File: tb/tb_rupt_priority.sv
// ---------------------------------------------------------------------------
// tb_rupt_priority
// Self-checking bench for rupt_priority (NRUPT=10, LOCK_LIM=4). Directed
// scenarios check against literal expected values; a randomized phase
// checks every output each cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_rupt_priority;

   localparam int NR  = 10;
   localparam int LIM = 4;

   localparam int M_IDLE    = 0;
   localparam int M_OFFER   = 1;
   localparam int M_SERVICE = 2;

   logic          SIM_CLK;
   logic          SIM_RST;
   logic [NR-1:0] RQ_PLS;
   logic          T12;
   logic          INHINT;
   logic          OVINH;
   logic          EXTP;
   logic          KRPT;
   logic          RESUME;
   logic          RUPTOR;
   logic          IIP;
   logic [11:0]   RADDR;
   logic [NR-1:0] PEND;
   logic          RLOCK;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Behavioural model state
   int            m_mode;
   int            m_idx;
   int            m_lock;
   logic [NR-1:0] m_pend;

   rupt_priority #(
      .NRUPT    (NR),
      .LOCK_LIM (LIM)
   ) dut (
      .SIM_CLK (SIM_CLK),
      .SIM_RST (SIM_RST),
      .RQ_PLS  (RQ_PLS),
      .T12     (T12),
      .INHINT  (INHINT),
      .OVINH   (OVINH),
      .EXTP    (EXTP),
      .KRPT    (KRPT),
      .RESUME  (RESUME),
      .RUPTOR  (RUPTOR),
      .IIP     (IIP),
      .RADDR   (RADDR),
      .PEND    (PEND),
      .RLOCK   (RLOCK)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      SIM_CLK = 1'b0;
      forever #5 SIM_CLK = ~SIM_CLK;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int lowest_set(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic [11:0] vec_of(input int idx);
      return 12'(2048 + 4 * (idx + 1));
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_idx  = 0;
      m_lock = 0;
      m_pend = '0;
   endtask

   // One clock of the model, using the inputs as sampled at the edge.
   task automatic model_step();
      logic          inh;
      logic [NR-1:0] p;
      p   = m_pend;
      inh = INHINT | OVINH | EXTP;
      case (m_mode)
         M_IDLE: begin
            if (T12 && (m_pend != 0) && !inh) begin
               m_mode = M_OFFER;
               m_idx  = lowest_set(m_pend);
            end
         end
         M_OFFER: begin
            if (KRPT) begin
               m_mode   = M_SERVICE;
               p[m_idx] = 1'b0;
               m_lock   = 0;
            end else if (T12 && inh) begin
               m_mode = M_IDLE;
            end
         end
         default: begin
            if (RESUME) begin
               m_mode = M_IDLE;
               m_lock = 0;
            end else if (T12 && (m_lock < LIM)) begin
               m_lock = m_lock + 1;
            end
         end
      endcase
      m_pend = p | RQ_PLS;
   endtask

   // Apply one cycle of pulse inputs, advance the model, return #1 after edge.
   task automatic drive_cycle(input logic [NR-1:0] rq, input logic t12,
                              input logic krpt, input logic resume);
      RQ_PLS = rq;
      T12    = t12;
      KRPT   = krpt;
      RESUME = resume;
      @(posedge SIM_CLK);
      model_step();
      #1;
      RQ_PLS = '0;
      T12    = 1'b0;
      KRPT   = 1'b0;
      RESUME = 1'b0;
   endtask

   // Return to IDLE with nothing pending, whatever state was left behind.
   task automatic drain();
      INHINT = 1'b0;
      OVINH  = 1'b0;
      EXTP   = 1'b0;
      if (m_mode == M_OFFER) drive_cycle('0, 1'b0, 1'b1, 1'b0);
      if (m_mode == M_SERVICE) drive_cycle('0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; (k < 20) && (m_pend != 0); k++) begin
         drive_cycle('0, 1'b1, 1'b0, 1'b0);
         drive_cycle('0, 1'b0, 1'b1, 1'b0);
         drive_cycle('0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_reset();
      SIM_RST = 1'b1;
      RQ_PLS  = '0;
      T12     = 1'b0;
      INHINT  = 1'b0;
      OVINH   = 1'b0;
      EXTP    = 1'b0;
      KRPT    = 1'b0;
      RESUME  = 1'b0;
      model_reset();
      #2;
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ruptor: got %b want 0", RUPTOR); end
      n_compared++; if (IIP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_iip: got %b want 0", IIP); end
      n_compared++; if (RLOCK !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rlock: got %b want 0", RLOCK); end
      n_compared++; if (RADDR !== 12'o4004) begin n_mismatched++; $display("[TB] FAIL reset_raddr: got %o want 4004", RADDR); end
      n_compared++; if (PEND !== 10'h000) begin n_mismatched++; $display("[TB] FAIL reset_pend: got %h want 000", PEND); end
      @(posedge SIM_CLK);
      #1;
      SIM_RST = 1'b0;
   endtask

   task automatic test_priority();
      drive_cycle(10'b0000001010, 1'b0, 1'b0, 1'b0);
      n_compared++; if (PEND !== 10'b0000001010) begin n_mismatched++; $display("[TB] FAIL prio_pend_latch: got %b want 0000001010", PEND); end
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL prio_no_t12: got %b want 0", RUPTOR); end
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RUPTOR !== 1'b1) begin n_mismatched++; $display("[TB] FAIL prio_offer: got %b want 1", RUPTOR); end
      n_compared++; if (RADDR !== 12'o4010) begin n_mismatched++; $display("[TB] FAIL prio_raddr: got %o want 4010", RADDR); end
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      n_compared++; if (PEND !== 10'b0000001000) begin n_mismatched++; $display("[TB] FAIL prio_take_pend: got %b want 0000001000", PEND); end
      n_compared++; if (IIP !== 1'b1) begin n_mismatched++; $display("[TB] FAIL prio_take_iip: got %b want 1", IIP); end
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL prio_take_ruptor: got %b want 0", RUPTOR); end
      drive_cycle('0, 1'b0, 1'b0, 1'b1);
      n_compared++; if (IIP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL prio_resume_iip: got %b want 0", IIP); end
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RADDR !== 12'o4020) begin n_mismatched++; $display("[TB] FAIL prio_second_raddr: got %o want 4020", RADDR); end
      drain();
   endtask

   task automatic test_inhibit();
      INHINT = 1'b1;
      drive_cycle(10'b0000000001, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive_cycle('0, 1'b1, 1'b0, 1'b0);
         n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL inh_ruptor[%0d]: got %b want 0", k, RUPTOR); end
      end
      n_compared++; if (PEND[0] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL inh_pend0: got %b want 1", PEND[0]); end
      INHINT = 1'b0;
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RUPTOR !== 1'b1) begin n_mismatched++; $display("[TB] FAIL inh_release_ruptor: got %b want 1", RUPTOR); end
      n_compared++; if (RADDR !== 12'o4004) begin n_mismatched++; $display("[TB] FAIL inh_release_raddr: got %o want 4004", RADDR); end
      drain();
   endtask

   task automatic test_backoff();
      drive_cycle(10'h020, 1'b0, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RADDR !== 12'o4030) begin n_mismatched++; $display("[TB] FAIL bo_offer_raddr: got %o want 4030", RADDR); end
      drive_cycle(10'h002, 1'b0, 1'b0, 1'b0);
      n_compared++; if (RADDR !== 12'o4030) begin n_mismatched++; $display("[TB] FAIL bo_idx_held: got %o want 4030", RADDR); end
      n_compared++; if (RUPTOR !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bo_still_offer: got %b want 1", RUPTOR); end
      EXTP = 1'b1;
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bo_withdraw: got %b want 0", RUPTOR); end
      n_compared++; if (PEND !== 10'h022) begin n_mismatched++; $display("[TB] FAIL bo_pend_kept: got %h want 022", PEND); end
      EXTP = 1'b0;
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RADDR !== 12'o4010) begin n_mismatched++; $display("[TB] FAIL bo_reoffer_raddr: got %o want 4010", RADDR); end
      INHINT = 1'b1;
      drive_cycle('0, 1'b1, 1'b1, 1'b0);
      INHINT = 1'b0;
      n_compared++; if (IIP !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bo_krpt_wins: got %b want 1", IIP); end
      n_compared++; if (PEND !== 10'h020) begin n_mismatched++; $display("[TB] FAIL bo_take_pend: got %h want 020", PEND); end
      drive_cycle(10'h100, 1'b0, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b1);
      n_compared++; if (IIP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bo_resume_iip: got %b want 0", IIP); end
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bo_no_same_edge_offer: got %b want 0", RUPTOR); end
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RADDR !== 12'o4030) begin n_mismatched++; $display("[TB] FAIL bo_next_offer_raddr: got %o want 4030", RADDR); end
      drain();
   endtask

   task automatic test_set_wins();
      drive_cycle(10'h004, 1'b0, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RADDR !== 12'o4014) begin n_mismatched++; $display("[TB] FAIL sw_raddr: got %o want 4014", RADDR); end
      drive_cycle(10'h004, 1'b0, 1'b1, 1'b0);
      n_compared++; if (IIP !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sw_iip: got %b want 1", IIP); end
      n_compared++; if (PEND[2] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sw_pend2: got %b want 1", PEND[2]); end
      drive_cycle('0, 1'b0, 1'b0, 1'b1);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RUPTOR !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sw_reoffer: got %b want 1", RUPTOR); end
      n_compared++; if (RADDR !== 12'o4014) begin n_mismatched++; $display("[TB] FAIL sw_reoffer_raddr: got %o want 4014", RADDR); end
      drain();
   endtask

   task automatic test_ignored();
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      n_compared++; if (IIP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_krpt_idle: got %b want 0", IIP); end
      drive_cycle('0, 1'b0, 1'b0, 1'b1);
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_resume_idle: got %b want 0", RUPTOR); end
      drive_cycle(10'h200, 1'b0, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      drive_cycle(10'h200, 1'b0, 1'b1, 1'b0);
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      n_compared++; if (IIP !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ign_krpt_service_iip: got %b want 1", IIP); end
      n_compared++; if (PEND !== 10'h200) begin n_mismatched++; $display("[TB] FAIL ign_krpt_service_pend: got %h want 200", PEND); end
      drain();
   endtask

   task automatic test_lock();
      drive_cycle(10'h080, 1'b0, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         drive_cycle('0, 1'b1, 1'b0, 1'b0);
         n_compared++; if (RLOCK !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lock_early[%0d]: got %b want 0", k, RLOCK); end
      end
      drive_cycle('0, 1'b0, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RLOCK !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lock_fourth: got %b want 1", RLOCK); end
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RLOCK !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lock_hold: got %b want 1", RLOCK); end
      drive_cycle('0, 1'b0, 1'b0, 1'b1);
      n_compared++; if (RLOCK !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lock_resume_rlock: got %b want 0", RLOCK); end
      n_compared++; if (IIP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL lock_resume_iip: got %b want 0", IIP); end
      drain();
   endtask

   task automatic test_reset_mid_service();
      drive_cycle(10'h050, 1'b0, 1'b0, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      #1;
      SIM_RST = 1'b1;
      model_reset();
      #1;
      n_compared++; if (IIP !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_iip: got %b want 0", IIP); end
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_ruptor: got %b want 0", RUPTOR); end
      n_compared++; if (RLOCK !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_rlock: got %b want 0", RLOCK); end
      n_compared++; if (RADDR !== 12'o4004) begin n_mismatched++; $display("[TB] FAIL mid_rst_raddr: got %o want 4004", RADDR); end
      n_compared++; if (PEND !== 10'h000) begin n_mismatched++; $display("[TB] FAIL mid_rst_pend: got %h want 000", PEND); end
      SIM_RST = 1'b0;
      drive_cycle('0, 1'b1, 1'b0, 1'b0);
      n_compared++; if (RUPTOR !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_stay_idle: got %b want 0", RUPTOR); end
   endtask

   task automatic test_random();
      logic [NR-1:0] rq;
      logic          t12;
      logic          krpt;
      logic          res;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(9) == 0) INHINT = ($urandom_range(9) < 3);
         if ($urandom_range(9) == 0) OVINH  = ($urandom_range(9) < 2);
         if ($urandom_range(9) == 0) EXTP   = ($urandom_range(9) < 2);
         rq   = NR'($urandom & $urandom & $urandom);
         t12  = ($urandom_range(2) == 0);
         krpt = ($urandom_range(3) == 0);
         res  = ($urandom_range(5) == 0);
         drive_cycle(rq, t12, krpt, res);
         n_compared++; if (RUPTOR !== (m_mode == M_OFFER)) begin n_mismatched++; $display("[TB] FAIL rnd_ruptor@%0d: got %b want %b", c, RUPTOR, (m_mode == M_OFFER)); end
         n_compared++; if (IIP !== (m_mode == M_SERVICE)) begin n_mismatched++; $display("[TB] FAIL rnd_iip@%0d: got %b want %b", c, IIP, (m_mode == M_SERVICE)); end
         n_compared++; if (RLOCK !== ((m_mode == M_SERVICE) && (m_lock >= LIM))) begin n_mismatched++; $display("[TB] FAIL rnd_rlock@%0d: got %b want %b", c, RLOCK, ((m_mode == M_SERVICE) && (m_lock >= LIM))); end
         n_compared++; if (RADDR !== vec_of(m_idx)) begin n_mismatched++; $display("[TB] FAIL rnd_raddr@%0d: got %o want %o", c, RADDR, vec_of(m_idx)); end
         n_compared++; if (PEND !== m_pend) begin n_mismatched++; $display("[TB] FAIL rnd_pend@%0d: got %h want %h", c, PEND, m_pend); end
      end
      drain();
   endtask

   initial begin
      $display("[TB] rupt_priority bench start");
      test_reset();
      test_priority();
      test_inhibit();
      test_backoff();
      test_set_wins();
      test_ignored();
      test_lock();
      test_reset_mid_service();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/rupt_priority.md
RUPT_PRIORITY -- requirements
Module: rupt_priority

Interface
REQ-001 Parameter NRUPT, 10, number of interrupt sources; index 0 is highest priority (T6RUPT).
REQ-002 Parameter LOCK_LIM, 1400, T12 strobes allowed in service before RLOCK asserts.
REQ-003 SIM_CLK  in  1  single system clock; all state changes on rising edge.
REQ-004 SIM_RST  in  1  reset, asynchronous, active-high.
REQ-005 RQ_PLS  in  NRUPT  one-cycle request pulses, one bit per source.
REQ-006 T12  in  1  one-cycle end-of-memory-cycle strobe; sole evaluation point.
REQ-007 INHINT  in  1  level, program interrupt inhibit.
REQ-008 OVINH  in  1  level, accumulator overflow inhibit.
REQ-009 EXTP  in  1  level, extend pending; interrupts barred.
REQ-010 KRPT  in  1  one-cycle take pulse from sequencer when RUPT instruction starts.
REQ-011 RESUME  in  1  one-cycle pulse at RESUME instruction completion.
REQ-012 RUPTOR  out  1  interrupt offered to sequencer.
REQ-013 IIP  out  1  interrupt in progress.
REQ-014 RADDR  out  12  vector address, octal 04000 + 4*(idx+1).
REQ-015 PEND  out  NRUPT  latched pending requests.
REQ-016 RLOCK  out  1  rupt-lock alarm, level.

Function
REQ-017 RQ_PLS bit k sets PEND[k]; pulses on already-pending bits have no effect.
REQ-018 States IDLE, OFFER, SERVICE.
REQ-019 IDLE -> OFFER on T12 when PEND nonzero and INHINT, OVINH, EXTP all low; idx latched = lowest set PEND bit.
REQ-020 OFFER: RUPTOR=1, RADDR driven from latched idx; later higher-priority arrivals do not change idx.
REQ-021 OFFER -> IDLE on T12 if any of INHINT/OVINH/EXTP high and KRPT absent; PEND unchanged, RUPTOR drops next cycle.
REQ-022 OFFER -> SERVICE on KRPT; PEND[idx] cleared same edge, IIP=1, RUPTOR=0.
REQ-023 KRPT in IDLE or SERVICE is ignored.
REQ-024 SERVICE -> IDLE on RESUME; IIP=0 same edge; new offer earliest at following T12.
REQ-025 RESUME outside SERVICE ignored.
REQ-026 RQ_PLS on bit idx coincident with KRPT: set wins, PEND[idx] stays 1.
REQ-027 KRPT and T12 coincident in OFFER: KRPT wins, inhibit evaluation skipped.
REQ-028 Lock counter, ceil(log2(LOCK_LIM+1)) bits: cleared on SERVICE entry, +1 per T12 in SERVICE, saturates at LOCK_LIM.
REQ-029 RLOCK=1 when counter reaches LOCK_LIM while in SERVICE; stays set until RESUME or reset.
REQ-030 RUPTOR, IIP, RLOCK are registered outputs; no combinational path from inputs.

Reset
REQ-031 SIM_RST high: state IDLE, PEND=0, idx=0, RADDR=04004, RUPTOR=0, IIP=0, RLOCK=0, counter=0, immediately, regardless of clock.
REQ-032 Reset mid-OFFER or mid-SERVICE discards the latched idx and all pending requests.
REQ-033 First evaluation after release is at the first T12 seen after SIM_RST falls.

Structure
REQ-034 Shared package agc_rupt_pkg holds the state enum, NRUPT_DEF, RUPT_BASE (octal 04000) and vector stride 4.
REQ-035 Lock counter is sub-module rupt_lock_timer (inputs clear, tick, LOCK_LIM parameter; output expired).
REQ-036 Priority encoder and vector mapping are inline combinational logic.

Verification
REQ-037 Pulse RQ_PLS bits 3 and 1, then T12 -> OFFER, RUPTOR=1, RADDR=04010; KRPT -> PEND=0b0000001000, IIP=1.
REQ-038 INHINT=1, RQ_PLS bit 0, five T12 -> RUPTOR stays 0, PEND bit0=1; INHINT=0, T12 -> RADDR=04004.
REQ-039 In OFFER on idx 2, RQ_PLS bit 2 with KRPT same cycle -> SERVICE, PEND[2]=1; RESUME, T12 -> re-offer RADDR=04014.
REQ-040 LOCK_LIM=4: SERVICE, 4 T12 -> RLOCK=1 after the 4th; RESUME -> RLOCK=0, IIP=0.
REQ-041 SIM_RST asserted mid-SERVICE without clock edge -> all outputs at reset values; first T12 after release with PEND=0 -> stays IDLE.
